// File: rtl/z_result_drain.sv
// Purpose : latch the 64-bit ALU result into ZHI/ZLO and drain it to the 32-bit bus word by word.
// Latency : capture at edge N -> bus_valid with ZLO from edge N; narrow ready at N+1, wide ready at N+2 with ack held.
// Backpr. : a word is held stable on BusOut/dest until bus_ack; captures while busy are dropped and flag overrun.
//
// Ports:
//   clock, clear            - rising-edge clock, synchronous active-high reset
//   C, capture, wide        - ALU result, capture strobe, two-word (MUL/DIV) select
//   ready                   - idle, next capture will be accepted
//   bus_valid, BusOut, dest - word on offer and its destination (00 none, 01 GPR, 10 LO, 11 HI)
//   bus_ack                 - consumer accepts the offered word this cycle
//   ZHI, ZLO                - latched result registers
//   overrun                 - sticky: capture seen while busy

module z_result_drain #(
  parameter int WORD = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [2*WORD-1:0] C,
  input  logic              capture,
  input  logic              wide,
  output logic              ready,
  output logic              bus_valid,
  output logic [WORD-1:0]   BusOut,
  output logic [1:0]        dest,
  input  logic              bus_ack,
  output logic [WORD-1:0]   ZHI,
  output logic [WORD-1:0]   ZLO,
  output logic              overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SEND_LO = 2'b01,
    SEND_HI = 2'b10
  } state_t;

  localparam logic [1:0] DEST_NONE = 2'b00;
  localparam logic [1:0] DEST_GPR  = 2'b01;
  localparam logic [1:0] DEST_LO   = 2'b10;
  localparam logic [1:0] DEST_HI   = 2'b11;

  state_t state, next_state;
  logic   wide_q;

  // State and result registers. The result is only latched from IDLE, so a
  // word on offer can never change underneath the consumer.
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      ZHI     <= '0;
      ZLO     <= '0;
      wide_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= next_state;
      if (capture) begin
        if (state == IDLE) begin
          ZLO    <= C[WORD-1:0];
          ZHI    <= C[2*WORD-1:WORD];
          wide_q <= wide;
        end else begin
          // Includes the final-word ack cycle: the block is not ready yet.
          overrun <= 1'b1;
        end
      end
    end
  end

  // Next state and Moore output decode; outputs depend only on state and
  // registered data, never on bus_ack or capture.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    bus_valid  = 1'b0;
    BusOut     = '0;
    dest       = DEST_NONE;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (capture) next_state = SEND_LO;
      end
      SEND_LO: begin
        bus_valid = 1'b1;
        BusOut    = ZLO;
        dest      = wide_q ? DEST_LO : DEST_GPR;
        if (bus_ack) next_state = wide_q ? SEND_HI : IDLE;
      end
      SEND_HI: begin
        bus_valid = 1'b1;
        BusOut    = ZHI;
        dest      = DEST_HI;
        if (bus_ack) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_z_result_drain.sv
// Purpose : directed checks of z_result_drain against hand-computed values.
// Latency : fixed cycle stepping; inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : consumer ack is driven explicitly per scenario.

module tb_z_result_drain;

  logic        clock;
  logic        clear;
  logic [63:0] C;
  logic        capture;
  logic        wide;
  logic        ready;
  logic        bus_valid;
  logic [31:0] BusOut;
  logic [1:0]  dest;
  logic        bus_ack;
  logic [31:0] ZHI;
  logic [31:0] ZLO;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  z_result_drain #(.WORD(32)) dut (
    .clock     (clock),
    .clear     (clear),
    .C         (C),
    .capture   (capture),
    .wide      (wide),
    .ready     (ready),
    .bus_valid (bus_valid),
    .BusOut    (BusOut),
    .dest      (dest),
    .bus_ack   (bus_ack),
    .ZHI       (ZHI),
    .ZLO       (ZLO),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear   = 1'b1;
    C       = '0;
    capture = 1'b0;
    wide    = 1'b0;
    bus_ack = 1'b0;
    tick();
    tick();
    clear = 1'b0;

    // Reset state
    chk("rst_ready", ready, 1);
    chk("rst_valid", bus_valid, 0);
    chk("rst_busout", BusOut, 0);
    chk("rst_dest", dest, 0);
    chk("rst_zhi", ZHI, 0);
    chk("rst_zlo", ZLO, 0);
    chk("rst_overrun", overrun, 0);

    // Narrow op: one word 0x2A to a GPR
    C = 64'h0000_0000_0000_002A; wide = 1'b0; capture = 1'b1;
    tick();
    capture = 1'b0;
    chk("nar_valid", bus_valid, 1);
    chk("nar_ready", ready, 0);
    chk("nar_busout", BusOut, 32'h2A);
    chk("nar_dest", dest, 2'b01);
    chk("nar_zhi", ZHI, 0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("nar_done_ready", ready, 1);
    chk("nar_done_valid", bus_valid, 0);
    chk("nar_done_dest", dest, 0);

    // Wide MUL -2 with ack held high
    C = 64'hFFFF_FFFF_FFFF_FFFE; wide = 1'b1; capture = 1'b1; bus_ack = 1'b1;
    tick();
    capture = 1'b0;
    chk("mul_lo_valid", bus_valid, 1);
    chk("mul_lo_busout", BusOut, 32'hFFFF_FFFE);
    chk("mul_lo_dest", dest, 2'b10);
    tick();
    chk("mul_hi_valid", bus_valid, 1);
    chk("mul_hi_busout", BusOut, 32'hFFFF_FFFF);
    chk("mul_hi_dest", dest, 2'b11);
    tick();
    chk("mul_done_ready", ready, 1);
    chk("mul_done_valid", bus_valid, 0);
    chk("mul_zhi", ZHI, 32'hFFFF_FFFF);
    chk("mul_zlo", ZLO, 32'hFFFF_FFFE);

    // Ack while idle is ignored
    tick();
    bus_ack = 1'b0;
    chk("idle_ack_ready", ready, 1);
    chk("idle_ack_valid", bus_valid, 0);

    // Backpressure on a DIV result
    C = 64'h0000_0003_0000_0007; wide = 1'b1; capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_busout", BusOut, 32'h7);
      chk("bp_hold_dest", dest, 2'b10);
      chk("bp_hold_valid", bus_valid, 1);
      tick();
    end
    bus_ack = 1'b1;
    chk("bp_lo_busout", BusOut, 32'h7);
    tick();
    chk("bp_hi_busout", BusOut, 32'h3);
    chk("bp_hi_dest", dest, 2'b11);
    tick();
    bus_ack = 1'b0;
    chk("bp_done_ready", ready, 1);

    // Overrun: second capture while in SEND_LO is dropped
    C = 64'h11; wide = 1'b0; capture = 1'b1;
    tick();
    C = 64'h22;
    chk("ovr_pre_flag", overrun, 0);
    tick();
    capture = 1'b0;
    chk("ovr_flag", overrun, 1);
    chk("ovr_zlo", ZLO, 32'h11);
    chk("ovr_busout", BusOut, 32'h11);
    chk("ovr_dest", dest, 2'b01);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("ovr_done_ready", ready, 1);
    chk("ovr_sticky", overrun, 1);

    // Clear mid-SEND_HI
    C = 64'h0000_00BB_0000_00AA; wide = 1'b1; capture = 1'b1;
    tick();
    capture = 1'b0;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("clr_pre_busout", BusOut, 32'hBB);
    chk("clr_pre_dest", dest, 2'b11);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ready", ready, 1);
    chk("clr_valid", bus_valid, 0);
    chk("clr_dest", dest, 0);
    chk("clr_zhi", ZHI, 0);
    chk("clr_zlo", ZLO, 0);
    chk("clr_overrun", overrun, 0);
    tick();
    chk("clr_still_idle", bus_valid, 0);

    // Capture and ack together in SEND_HI
    C = 64'h0000_0005_0000_0009; wide = 1'b1; capture = 1'b1;
    tick();
    capture = 1'b0;
    bus_ack = 1'b1;
    tick();
    chk("sim_hi_busout", BusOut, 32'h5);
    C = 64'hAAAA_AAAA_BBBB_BBBB; wide = 1'b0; capture = 1'b1;
    tick();
    capture = 1'b0;
    bus_ack = 1'b0;
    chk("sim_ready", ready, 1);
    chk("sim_valid", bus_valid, 0);
    chk("sim_overrun", overrun, 1);
    chk("sim_zhi", ZHI, 32'h5);
    chk("sim_zlo", ZLO, 32'h9);

    // One idle cycle later a new capture is accepted
    C = 64'h0000_0000_0000_0042; wide = 1'b0; capture = 1'b1;
    tick();
    capture = 1'b0;
    chk("post_busout", BusOut, 32'h42);
    chk("post_dest", dest, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z_result_drain.md
# z_result_drain

Sequential drain stage for the 64-bit ALU result. It latches the ALU output `C` into the ZHI/ZLO registers on a capture strobe, then presents the result to the 32-bit datapath bus one word at a time through a valid/ack handshake. Narrow operations (logic, add/sub, shifts, rotates, IncPC, branch target) drain one word to a general register. Wide operations (MUL, DIV) drain two words: ZLO to LO, then ZHI to HI.

## Interface
Parameters:
- `WORD`, default 32, bus word width; `C` is 2*WORD bits.

Ports:
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `clear`  in  1  reset, synchronous and active-high.
- `C`  in  64  ALU result; `[31:0]` is the low word, `[63:32]` is the high word (remainder for DIV).
- `capture`  in  1  Zin strobe; latch `C` this cycle.
- `wide`  in  1  sampled with `capture`; 1 = MUL/DIV (two words), 0 = all other ops (one word).
- `ready`  out  1  block idle; a capture will be accepted.
- `bus_valid`  out  1  `BusOut` holds a word awaiting acceptance.
- `BusOut`  out  32  word presented to the bus.
- `dest`  out  2  destination of the current word: 00 none, 01 GPR, 10 LO, 11 HI.
- `bus_ack`  in  1  consumer takes the word this cycle.
- `ZHI`, `ZLO`  out  32 each  latched result registers, always visible.
- `overrun`  out  1  sticky flag: a capture arrived while not ready.

## Operation
- States: IDLE, SEND_LO, SEND_HI.
- **IDLE**
  - `ready`=1, `bus_valid`=0, `dest`=00, `BusOut`=0.
  - If `capture`: ZLO<=`C[31:0]`, ZHI<=`C[63:32]`, wide_q<=`wide`, next state SEND_LO.
- **SEND_LO**
  - `bus_valid`=1, `BusOut`=ZLO, `dest`=10 if wide_q else 01.
  - If `bus_ack`: next state SEND_HI if wide_q, otherwise IDLE.
  - Without `bus_ack`, hold all outputs stable indefinitely.
- **SEND_HI**
  - `bus_valid`=1, `BusOut`=ZHI, `dest`=11.
  - If `bus_ack`: next state IDLE.
- **Capture while busy:** a `capture` in SEND_LO or SEND_HI is ignored. ZHI, ZLO and wide_q are unchanged, and `overrun`<=1. `overrun` stays set until `clear`.
- **Ack outside a transfer:** `bus_ack` in IDLE is ignored.
- **Capture and ack in the same cycle** in the final send state: the ack completes the transfer and the capture counts as an overrun. Accepting back-to-back captures requires one IDLE cycle.
- **Width rule:** ZHI/ZLO are copied from `C` bit-exact, with no sign or zero manipulation. For narrow ops, ZHI still latches `C[63:32]` (expected 0) but is never driven on the bus.
- **`clear`** has priority over every other input in every state: state<=IDLE, ZHI<=0, ZLO<=0, wide_q<=0, overrun<=0. A transfer in flight is abandoned with no further `bus_valid`.

## Timing
- Reset values after `clear`:
  - `ready`=1, `bus_valid`=0, `BusOut`=0, `dest`=00.
  - ZHI=0, ZLO=0, `overrun`=0.
- Capture latency: `capture` sampled at edge N gives `bus_valid`=1 with ZLO on `BusOut` from edge N through the next edge.
- Outputs are registered-state decodes (Moore), so `ready`, `bus_valid`, `BusOut` and `dest` never depend combinationally on `bus_ack` or `capture`.
- Minimum occupancy with `bus_ack` held high:
  - Narrow: capture edge N, word accepted at edge N+1, `ready` at N+1.
  - Wide: LO accepted at N+1, HI at N+2, `ready` at N+2.
- A word is transferred exactly on an edge where `bus_valid`=1 and `bus_ack`=1.

## Test plan
- **Reset:** drive `clear` for one cycle mid-SEND_HI -> next cycle `ready`=1, `bus_valid`=0, ZHI=ZLO=0, `dest`=00, `overrun`=0.
- **Narrow op:** `C`=0x0000_0000_0000_002A, `wide`=0, capture, then ack -> one word 0x2A with `dest`=01, then `ready`=1. ZHI=0 is never driven.
- **Wide MUL:** `C`=0xFFFF_FFFF_FFFF_FFFE (-2), `wide`=1, ack held high.
  - Edge N+1: 0xFFFF_FFFE with `dest`=10.
  - Edge N+2: 0xFFFF_FFFF with `dest`=11.
  - Then IDLE.
- **Backpressure:** DIV result `C`=0x0000_0003_0000_0007, hold `bus_ack`=0 for 5 cycles -> `BusOut`=7 with `dest`=10 held stable. Then ack twice -> 7 then 3 with `dest`=11.
- **Overrun:** capture `C`=0x11, then capture `C`=0x22 while in SEND_LO -> `overrun`=1, ZLO stays 0x11, and the drained word is 0x11.
- **Simultaneous events:** in SEND_HI, assert `bus_ack` and `capture` together -> HI word accepted, `overrun`=1, next state IDLE, ZHI/ZLO unchanged.
